// File: rtl/soc_wb_pkg.sv
// Shared Wishbone definitions for the SoC: bus widths, RAM window and arbiter FSM states.
`timescale 1ns/1ps
package soc_wb_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_SW = WB_DW / 8;

    localparam logic [WB_AW-1:0] RAM_BASE = 32'h4000_0000;
    localparam logic [WB_AW-1:0] RAM_SIZE = 32'h0200_0000;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ABORT
    } wb_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping, as a one-hot vector.
`timescale 1ns/1ps
module rr_pick #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Frame-buffer RAM Wishbone arbiter: bounded-priority video_out port, round-robin for the rest,
// and a watchdog that aborts cycles the slave never answers.
`timescale 1ns/1ps
module wb_ram_arbiter
    import soc_wb_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 3,
    parameter int unsigned HIPRI_PORT  = 0,
    parameter int unsigned HIPRI_BURST = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                         p_clk,
    input  logic                         p_resetn,
    input  logic [N_MASTERS-1:0]         m_cyc_i,
    input  logic [N_MASTERS-1:0]         m_stb_i,
    input  logic [N_MASTERS-1:0]         m_we_i,
    input  logic [N_MASTERS-1:0]         m_lock_i,
    input  logic [WB_AW*N_MASTERS-1:0]   m_adr_i,
    input  logic [WB_DW*N_MASTERS-1:0]   m_dat_i,
    input  logic [WB_SW*N_MASTERS-1:0]   m_sel_i,
    output logic [WB_DW-1:0]             m_dat_o,
    output logic [N_MASTERS-1:0]         m_ack_o,
    output logic [N_MASTERS-1:0]         m_err_o,
    output logic [N_MASTERS-1:0]         m_rty_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic                         s_lock_o,
    output logic [WB_AW-1:0]             s_adr_o,
    output logic [WB_DW-1:0]             s_dat_o,
    output logic [WB_SW-1:0]             s_sel_o,
    input  logic [WB_DW-1:0]             s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    input  logic                         s_rty_i,
    output logic [N_MASTERS-1:0]         grant_o,
    output logic                         abort_o
);

    localparam int unsigned IW = $clog2(N_MASTERS);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned HW = $clog2(HIPRI_BURST + 2);

    localparam logic [N_MASTERS-1:0] HIPRI_MASK = {{(N_MASTERS-1){1'b0}}, 1'b1} << HIPRI_PORT;
    localparam logic [IW-1:0]        HIPRI_IDX  = IW'(HIPRI_PORT);
    localparam logic [IW-1:0]        RR_RESET   = IW'((HIPRI_PORT + 1) % N_MASTERS);

    wb_arb_state_t state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]        hipri_cnt_q, hipri_cnt_d;
    logic [WW-1:0]        wd_cnt_q, wd_cnt_d;
    logic [N_MASTERS-1:0] blocked_q, blocked_d;

    logic [N_MASTERS-1:0] req, req_rr, rr_gnt;
    logic [IW-1:0]        rr_idx;
    logic                 hipri_req, others_req, hipri_win;
    logic                 resp, own_cyc, own_stb, own_lock, stb_act;

    logic [WB_AW-1:0] adr_arr [N_MASTERS];
    logic [WB_DW-1:0] dat_arr [N_MASTERS];
    logic [WB_SW-1:0] sel_arr [N_MASTERS];

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            adr_arr[k] = m_adr_i[WB_AW*k +: WB_AW];
            dat_arr[k] = m_dat_i[WB_DW*k +: WB_DW];
            sel_arr[k] = m_sel_i[WB_SW*k +: WB_SW];
        end
    end

    // An aborted master stays masked until it has dropped CYC once.
    assign req        = m_cyc_i & ~blocked_q;
    assign req_rr     = req & ~HIPRI_MASK;
    assign hipri_req  = req[HIPRI_PORT];
    assign others_req = |req_rr;
    assign hipri_win  = hipri_req && (!others_req || (hipri_cnt_q < HW'(HIPRI_BURST)));

    rr_pick #(
        .N(N_MASTERS)
    ) u_rr_pick (
        .req_i(req_rr),
        .ptr_i(rr_ptr_q),
        .gnt_o(rr_gnt)
    );

    always_comb begin
        rr_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (rr_gnt[k]) begin
                rr_idx = IW'(k);
            end
        end
    end

    assign own_cyc  = m_cyc_i[owner_q];
    assign own_stb  = m_stb_i[owner_q];
    assign own_lock = m_lock_i[owner_q];
    assign stb_act  = own_cyc & own_stb;
    assign resp     = s_ack_i | s_err_i | s_rty_i;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hipri_cnt_d = hipri_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        blocked_d   = blocked_q & m_cyc_i;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d  = ARB_GRANT;
                    wd_cnt_d = '0;
                    if (hipri_win) begin
                        owner_d = HIPRI_IDX;
                        if (others_req && (hipri_cnt_q != HW'(HIPRI_BURST))) begin
                            hipri_cnt_d = hipri_cnt_q + 1'b1;
                        end
                    end else begin
                        owner_d     = rr_idx;
                        hipri_cnt_d = '0;
                        rr_ptr_d    = (rr_idx == IW'(N_MASTERS - 1)) ? '0 : rr_idx + 1'b1;
                    end
                end
            end
            ARB_GRANT: begin
                // Release beats timeout; a response beats timeout.
                if (!own_cyc && !own_lock) begin
                    state_d = ARB_IDLE;
                end else if (resp) begin
                    wd_cnt_d = '0;
                end else if (stb_act) begin
                    if (wd_cnt_q == WW'(TIMEOUT)) begin
                        state_d = ARB_ABORT;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            ARB_ABORT: begin
                state_d            = ARB_IDLE;
                blocked_d[owner_q] = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= RR_RESET;
            hipri_cnt_q <= '0;
            wd_cnt_q    <= '0;
            blocked_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            hipri_cnt_q <= hipri_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            blocked_q   <= blocked_d;
        end
    end

    always_comb begin
        m_dat_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        m_rty_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_lock_o = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        grant_o  = '0;
        abort_o  = 1'b0;
        case (state_q)
            ARB_GRANT: begin
                grant_o[owner_q] = 1'b1;
                s_cyc_o          = own_cyc;
                s_stb_o          = stb_act;
                s_we_o           = m_we_i[owner_q];
                s_lock_o         = own_lock;
                s_adr_o          = adr_arr[owner_q];
                s_dat_o          = dat_arr[owner_q];
                s_sel_o          = sel_arr[owner_q];
                m_dat_o          = s_dat_i;
                m_ack_o[owner_q] = s_ack_i;
                m_err_o[owner_q] = s_err_i;
                m_rty_o[owner_q] = s_rty_i;
            end
            ARB_ABORT: begin
                grant_o[owner_q] = 1'b1;
                m_err_o[owner_q] = 1'b1;
                abort_o          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a grant-order scoreboard and immediate-assertion checks.
`timescale 1ns/1ps
module tb_wb_ram_arbiter;

    localparam int N = 3;

    logic            p_clk = 1'b0;
    logic            p_resetn = 1'b0;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_lock_i;
    logic [32*N-1:0] m_adr_i, m_dat_i;
    logic [4*N-1:0]  m_sel_i;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]    grant_o;
    logic            abort_o;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    wb_ram_arbiter #(
        .N_MASTERS(N),
        .HIPRI_PORT(0),
        .HIPRI_BURST(4),
        .TIMEOUT(255)
    ) dut (
        .p_clk(p_clk), .p_resetn(p_resetn),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .abort_o(abort_o)
    );

    always #5 p_clk = ~p_clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 3 ns after it.
    task automatic cyc1();
        @(posedge p_clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic do_reset();
        p_resetn = 1'b0;
        m_cyc_i  = '0;
        m_stb_i  = '0;
        m_we_i   = '0;
        m_lock_i = '0;
        m_adr_i  = {N{32'h4000_0abc}};
        m_dat_i  = {N{32'h5555_aaaa}};
        m_sel_i  = '1;
        s_dat_i  = 32'hdead_beef;
        s_ack_i  = 1'b0;
        s_err_i  = 1'b0;
        s_rty_i  = 1'b0;
        repeat (2) cyc1();
        p_resetn = 1'b1;
    endtask

    // Masters in act request continuously; the slave ACKs each owner's first cycle, the owner
    // drops CYC for one cycle and requests again. Each new grant pops the next expected owner.
    task automatic run_sched(input logic [N-1:0] act, input int budget);
        logic [N-1:0] drop = '0;
        logic [N-1:0] prev_g = '0;
        int idle = 0;
        bit started = 0;
        int cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            cyc1();
            cycles++;
            m_cyc_i = act & ~drop;
            m_stb_i = act & ~drop;
            s_ack_i = |(grant_o & m_cyc_i);
            drop    = grant_o & m_cyc_i;
            look();
            if (grant_o == '0) begin
                idle++;
            end else begin
                if (prev_g == '0) begin
                    if (started) chk("sched_idle_gap", idle, 1);
                    started = 1;
                    chk("sched_grant_order", {29'd0, grant_o}, exp_q.pop_front());
                end
                idle = 0;
            end
            prev_g = grant_o;
        end
        if (exp_q.size() != 0) begin
            chk("sched_budget_left", exp_q.size(), 0);
            exp_q.delete();
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        repeat (3) cyc1();
    endtask

    initial begin
        int got;
        bit seen;

        // Reset state
        do_reset();
        look();
        chk("rst_grant", grant_o, 0);
        chk("rst_abort", abort_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_m_dat", m_dat_o, 0);

        // 1: master 1 read, ACK on the fourth granted cycle; then master 2 write with RTY
        cyc1();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b0;
        m_adr_i[63:32] = 32'h4000_0010; m_sel_i[7:4] = 4'h3;
        look();
        chk("t1_no_grant_yet", grant_o, 0);
        cyc1(); look();
        chk("t1_grant", grant_o, 3'b010);
        chk("t1_s_cyc", s_cyc_o, 1);
        chk("t1_s_adr", s_adr_o, 32'h4000_0010);
        chk("t1_s_sel", s_sel_o, 4'h3);
        cyc1(); cyc1();
        cyc1();
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        look();
        chk("t1_ack", m_ack_o, 3'b010);
        chk("t1_rdata", m_dat_o, exp_q.pop_front());
        cyc1();
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        look();
        chk("t1_ack_clear", m_ack_o, 0);
        cyc1(); look();
        chk("t1_released", grant_o, 0);
        chk("t1_m_dat_idle", m_dat_o, 0);
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_we_i[2] = 1'b1;
        m_dat_i[95:64] = 32'hcafe_f00d;
        cyc1(); look();
        chk("t1_w_grant", grant_o, 3'b100);
        chk("t1_w_we", s_we_o, 1);
        chk("t1_w_dat", s_dat_o, 32'hcafe_f00d);
        cyc1();
        s_rty_i = 1'b1;
        look();
        chk("t1_rty", m_rty_o, 3'b100);
        chk("t1_rty_no_ack", m_ack_o, 0);
        cyc1();
        s_rty_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        repeat (2) cyc1();

        // 2: masters 1 and 2 alternate
        do_reset();
        exp_q.push_back(32'b010); exp_q.push_back(32'b100);
        exp_q.push_back(32'b010); exp_q.push_back(32'b100);
        run_sched(3'b110, 40);

        // 3: bounded priority for master 0
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'b001);
        exp_q.push_back(32'b010);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'b001);
        exp_q.push_back(32'b100);
        run_sched(3'b111, 80);

        // 4: watchdog abort, blocking of the aborted master, response at the timeout cycle
        do_reset();
        cyc1();
        m_cyc_i = 3'b110; m_stb_i = 3'b110;
        cyc1(); look();
        chk("t4_grant", grant_o, 3'b010);
        got = -1;
        for (int i = 1; i < 300 && got < 0; i++) begin
            cyc1(); look();
            if (abort_o) got = i;
        end
        chk("t4_abort_at", got, 256);
        chk("t4_err_owner", m_err_o, 3'b010);
        chk("t4_abort_s_cyc", s_cyc_o, 0);
        cyc1(); look();
        chk("t4_abort_pulse", abort_o, 0);
        chk("t4_err_pulse", m_err_o, 0);
        cyc1(); look();
        chk("t4_next_owner", grant_o, 3'b100);
        m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        repeat (3) cyc1();
        look();
        chk("t4_blocked", grant_o, 0);
        cyc1();
        m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        cyc1();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        cyc1(); look();
        chk("t4_unblocked", grant_o, 3'b010);
        seen = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            cyc1();
            if (i == 255) s_ack_i = 1'b1;
            look();
            seen = seen | abort_o;
        end
        cyc1();
        s_ack_i = 1'b0;
        look();
        chk("t4_resp_wins_abort", abort_o, 0);
        chk("t4_resp_wins_grant", grant_o, 3'b010);
        chk("t4_no_early_abort", seen, 0);
        m_cyc_i = '0; m_stb_i = '0;
        repeat (3) cyc1();

        // 5: LOCK held by master 2 across two CYC cycles
        do_reset();
        cyc1();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_lock_i[2] = 1'b1;
        cyc1(); look();
        chk("t5_grant", grant_o, 3'b100);
        chk("t5_s_lock", s_lock_o, 1);
        cyc1();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; s_ack_i = 1'b1;
        look();
        chk("t5_ack", m_ack_o, 3'b100);
        cyc1();
        s_ack_i = 1'b0; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        look();
        chk("t5_hold_s_cyc", s_cyc_o, 0);
        repeat (3) cyc1();
        look();
        chk("t5_hold_grant", grant_o, 3'b100);
        chk("t5_hold_lock", s_lock_o, 1);
        cyc1();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1;
        look();
        chk("t5_second_cyc", s_cyc_o, 1);
        cyc1();
        s_ack_i = 1'b1;
        cyc1();
        s_ack_i = 1'b0; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0; m_lock_i[2] = 1'b0;
        look();
        chk("t5_release_cycle", grant_o, 3'b100);
        cyc1(); look();
        chk("t5_idle_gap", grant_o, 0);
        cyc1(); look();
        chk("t5_m1_granted", grant_o, 3'b010);
        m_cyc_i = '0; m_stb_i = '0;
        repeat (3) cyc1();

        // 6: reset during a transfer, then the reset round-robin pointer decides
        do_reset();
        cyc1();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        cyc1(); look();
        chk("t6_grant", grant_o, 3'b010);
        cyc1();
        p_resetn = 1'b0;
        look();
        chk("t6_rst_s_cyc", s_cyc_o, 0);
        chk("t6_rst_grant", grant_o, 0);
        cyc1();
        p_resetn = 1'b1;
        m_cyc_i = 3'b110; m_stb_i = 3'b110;
        cyc1(); look();
        chk("t6_first_after_reset", grant_o, 3'b010);
        m_cyc_i = '0; m_stb_i = '0;
        repeat (3) cyc1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
